word_packer: RTL

Upstream stage of `matcher`. Accepts a byte-per-cycle character stream over a valid/ready handshake, splits it on a delimiter, and packs each word into the fixed `WORD_LENGTH*DATA_WIDTH` bus that `matcher` consumes. The first character goes in the most-significant byte and unused trailing bytes are zero, so "Hel" is presented as {8'h48, 8'h65, 8'h6C}. Words longer than `WORD_LENGTH` are truncated and flagged.

---
 rtl/word_packer_if.sv | 28 ++
 rtl/word_packer.sv | 83 ++++++++
 2 files changed

// File: rtl/word_packer_if.sv
// Handshake bundle for word_packer: byte stream in, packed word out.
interface word_packer_if #(
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_W       = $clog2(WORD_LENGTH + 1)
) ();
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_valid;
  logic                              in_last;
  logic                              in_ready;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word;
  logic [LEN_W-1:0]                  word_len;
  logic                              word_trunc;
  logic                              word_valid;
  logic                              word_ready;

  // Driver side: feeds characters and consumes words.
  modport master (
    output in_data, in_valid, in_last, word_ready,
    input  in_ready, word, word_len, word_trunc, word_valid
  );

  // Packer side.
  modport slave (
    input  in_data, in_valid, in_last, word_ready,
    output in_ready, word, word_len, word_trunc, word_valid
  );
endinterface

// File: rtl/word_packer.sv
// Splits a byte stream on a delimiter and packs each word MSB-first into a
// fixed-width bus; over-long words are truncated and flagged.
module word_packer #(
  parameter int                    WORD_LENGTH = 3,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM       = 8'h20,
  parameter int                    LEN_W       = $clog2(WORD_LENGTH + 1)
) (
  input logic          clk,
  input logic          rst_n,
  word_packer_if.slave bus
);
  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] SKIP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [LEN_W-1:0] FULL = LEN_W'(WORD_LENGTH);

  logic [1:0]                        state;
  logic [LEN_W-1:0]                  cnt;
  logic                              trunc;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] data_buf;

  logic accept;
  logic is_delim;

  assign accept   = bus.in_valid && bus.in_ready;
  assign is_delim = (bus.in_data == DELIM);

  // Outputs come straight from state registers, so they hold while stalled.
  assign bus.in_ready   = (state != HOLD);
  assign bus.word_valid = (state == HOLD);
  assign bus.word       = data_buf;
  assign bus.word_len   = cnt;
  assign bus.word_trunc = trunc;

  // Word assembly FSM: FILL collects, SKIP discards overflow, HOLD presents.
  // NOTE: non-blocking assignments keep every register update in this block
  // reading pre-edge values, so store-at-cnt and cnt++ see the same cnt.
  // NOTE: the word buffer is a plain register (not a RAM) and is reset so the
  // bus reads zero after reset and a discarded partial word never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      cnt      <= '0;
      trunc    <= 1'b0;
      data_buf <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (is_delim) begin
              // Leading/repeated delimiters are dropped; otherwise close word.
              if (cnt != '0) state <= HOLD;
            end else if (cnt != FULL) begin
              for (int i = 0; i < WORD_LENGTH; i++) begin
                if (cnt == LEN_W'(i))
                  data_buf[(WORD_LENGTH-1-i)*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
              end
              cnt <= cnt + 1'b1;
              if (bus.in_last) state <= HOLD;
            end else begin
              trunc <= 1'b1;
              state <= bus.in_last ? HOLD : SKIP;
            end
          end
        end
        SKIP: begin
          if (accept && (is_delim || bus.in_last)) state <= HOLD;
        end
        HOLD: begin
          if (bus.word_ready) begin
            data_buf <= '0;
            cnt      <= '0;
            trunc    <= 1'b0;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
